// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, redirect squashes,
// data-memory freeze with timeout, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_STALL = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              stall_inc, flush_inc;
  logic              lu;

  // A load whose destination is $0 never creates a real dependency.
  assign lu = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // STALL and FLUSH share RUN's decode; WAIT does too once mem_busy drops.
  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    state_d      = S_RUN;
    wait_d       = '0;
    err_d        = err_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (state_q == S_HALT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = S_HALT;
      wait_d      = wait_q;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      wait_d      = (state_q == S_WAIT) ? wait_q + WAIT_W'(1) : WAIT_W'(1);
      if (wait_d >= WAIT_W'(MEM_TIMEOUT)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        state_d = S_WAIT;
      end
    end else if (redirect) begin
      // The load-use consumer is on the wrong path, so it is squashed, not stalled.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      flush_inc    = 1'b1;
      state_d      = S_FLUSH;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      state_d     = S_STALL;
    end

    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_write   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b0;
      exmem_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes model predictions per cycle,
// a monitor pops and compares them at the falling edge.
module tb_hazard_ctrl;

  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    logic [6:0] ctrl;   // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, exmem_bubble}
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             redirect;
  logic             mem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic             exmem_write, exmem_bubble, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model state: streak of busy cycles, halted flag, event tallies.
  int m_streak = 0;
  bit m_halted = 0;
  bit m_err    = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .redirect     (redirect),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .exmem_bubble (exmem_bubble),
    .err          (err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts this cycle's outputs and its next state.
  task automatic drive(input logic r, input logic mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic rd, input logic busy);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    rst_n = r; idex_memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
    ifid_uses_rt = urt; redirect = rd; mem_busy = busy;
    e.err   = m_err;
    e.stall = m_stall;
    e.flush = m_flush;
    hazard  = mr && (xrt != 0) && ((xrt == rs) || (urt && (xrt == rt)));
    if (!r) begin
      e.ctrl = 7'b0000000;
      m_streak = 0; m_halted = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      e.ctrl = 7'b0000000;
    end else if (busy) begin
      e.ctrl = 7'b0000000;
      m_streak++;
      if (m_streak >= MEM_TIMEOUT) begin
        m_halted = 1;
        m_err    = 1;
      end
    end else begin
      m_streak = 0;
      if (rd) begin
        e.ctrl  = 7'b1111111;
        m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      end else if (hazard) begin
        e.ctrl  = 7'b0001110;
        m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      end else begin
        e.ctrl = 7'b1101010;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctrl", {25'd0, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                       exmem_write, exmem_bubble}, {25'd0, e.ctrl});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("stall_cnt", {16'd0, stall_cnt}, e.stall);
        check("flush_cnt", {16'd0, flush_cnt}, e.flush);
      end
    end
  end

  initial begin
    int burst;
    rst_n = 0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rt = 0; redirect = 0; mem_busy = 0;

    do_reset(2);
    idle(2);
    // lw $5 in ID/EX, add $6,$5,$7 in IF/ID: single stall cycle
    drive(1, 1, 5'd5, 5'd5, 5'd7, 1, 0, 0);
    idle(2);
    // rt-only dependency, with and without ifid_uses_rt
    drive(1, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0);
    drive(1, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0);
    // load into $0 is never a hazard
    drive(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    // back-to-back stalls
    drive(1, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
    drive(1, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
    // redirect and load-use together: redirect wins
    drive(1, 1, 5'd4, 5'd4, 5'd4, 1, 1, 0);
    idle(1);
    // busy 3 cycles holding redirect, then the flush
    for (int i = 0; i < 3; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    idle(1);
    // one short of the timeout: no err
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    drive(1, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0);
    // full timeout, then halted regardless of inputs
    for (int i = 0; i < MEM_TIMEOUT; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    drive(1, 1, 5'd2, 5'd2, 5'd0, 0, 1, 0);
    @(negedge clk);
    check("err_after_timeout", {31'd0, err}, 32'd1);
    idle(2);
    do_reset(1);
    idle(1);
    @(negedge clk);
    check("err_after_reset", {31'd0, err}, 32'd0);

    // randomized traffic with occasional resets and busy bursts
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      logic b;
      if (burst == 0 && $urandom_range(0, 14) == 0) burst = $urandom_range(1, 18);
      b = (burst > 0);
      if (burst > 0) burst--;
      drive($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0, b);
    end

    // stall counter saturation
    do_reset(1);
    for (int i = 0; i < CNT_MAX + 4; i++) drive(1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
    @(negedge clk);
    check("stall_saturated", {16'd0, stall_cnt}, 32'h0000_FFFF);
    idle(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
